// File: rtl/data_mem_dump_ctrl_pkg.sv
// Shared constants for the data-memory dump controller: FSM state encodings
// and byte-lane sizing helpers derived from the data word width.
// Optional build macro: DUMP_CHECKSUM_EN adds a trailing XOR checksum byte.
package data_mem_dump_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_WAIT      = 3'd2,
      ST_LATCH     = 3'd3,
      ST_SEND      = 3'd4,
      ST_WAIT_TX   = 3'd5
`ifdef DUMP_CHECKSUM_EN
      ,
      ST_SEND_CSUM = 3'd6,
      ST_WAIT_CSUM = 3'd7
`endif
   } state_e;

   // Number of UART bytes per data word.
   function automatic int bytes_per_word(input int proc_bits);
      return proc_bits / 8;
   endfunction

   // Width of the byte index; at least one bit even for a single-byte word.
   function automatic int byte_idx_bits(input int proc_bits);
      return (proc_bits / 8 > 1) ? $clog2(proc_bits / 8) : 1;
   endfunction

endpackage

// File: rtl/data_mem_dump_ctrl_if.sv
// Bundle of the dump controller's pipeline, memory-stage and UART signals.
// master = the dump controller, slave = the surrounding memory stage / UART.
interface data_mem_dump_ctrl_if #(
   parameter int PROC_BITS       = 32,
   parameter int DATA_ADDRS_BITS = 10
);
   logic                       i_start;
   logic                       i_halted;
   logic [PROC_BITS-1:0]       i_mem_data;
   logic                       i_tx_done;
   logic                       o_debug_read_data;
   logic [DATA_ADDRS_BITS-1:0] o_debug_read_address;
   logic [7:0]                 o_tx_data;
   logic                       o_tx_start;
   logic                       o_busy;
   logic                       o_done;
   logic                       o_aborted;

   modport master (
      input  i_start, i_halted, i_mem_data, i_tx_done,
      output o_debug_read_data, o_debug_read_address, o_tx_data,
             o_tx_start, o_busy, o_done, o_aborted
   );

   modport slave (
      output i_start, i_halted, i_mem_data, i_tx_done,
      input  o_debug_read_data, o_debug_read_address, o_tx_data,
             o_tx_start, o_busy, o_done, o_aborted
   );
endinterface

// File: rtl/data_mem_dump_ctrl_word_byte_serializer.sv
// Holds one captured data word and walks it LSB byte first.
// With DUMP_CHECKSUM_EN defined it also keeps a running XOR of sent bytes.
module word_byte_serializer
   import data_mem_dump_ctrl_pkg::*;
#(
   parameter int PROC_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [PROC_BITS-1:0] word_i,
   input  logic                 advance_i,
`ifdef DUMP_CHECKSUM_EN
   input  logic                 csum_clr_i,
   input  logic                 csum_acc_i,
   output logic [7:0]           csum_o,
`endif
   output logic [7:0]           byte_o,
   output logic                 last_o
);

   localparam int BPW   = bytes_per_word(PROC_BITS);
   localparam int IDX_W = byte_idx_bits(PROC_BITS);

   logic [PROC_BITS-1:0] word_q, word_d;
   logic [IDX_W-1:0]     idx_q, idx_d;

   // Next word/index: a load restarts at byte 0, an advance steps one lane.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      word_d = word_q;
      idx_d  = idx_q;
      if (load_i) begin
         word_d = word_i;
         idx_d  = '0;
      end else if (advance_i) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   // Word and index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

   // Byte-lane multiplexer for the current index.
   always_comb begin
      byte_o = 8'h00;
      for (int b = 0; b < BPW; b++) begin
         if (idx_q == IDX_W'(b)) byte_o = word_q[8*b +: 8];
      end
   end

   assign last_o = (idx_q == IDX_W'(BPW - 1));

`ifdef DUMP_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;

   // Running XOR of every byte handed to the UART.
   always_comb begin
      csum_d = csum_q;
      if (csum_clr_i)      csum_d = 8'h00;
      else if (csum_acc_i) csum_d = csum_q ^ byte_o;
   end

   // Checksum register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) csum_q <= 8'h00;
      else     csum_q <= csum_d;
   end

   assign csum_o = csum_q;
`endif

endmodule

// File: rtl/data_mem_dump_ctrl.sv
// Debug dump sequencer for the data-memory BRAM: while the pipeline is
// halted it reads words 0..DUMP_WORDS-1 and streams them byte-wise to the
// debug UART. Optional build macro: DUMP_CHECKSUM_EN appends an XOR byte.
module data_mem_dump_ctrl
   import data_mem_dump_ctrl_pkg::*;
#(
   parameter int PROC_BITS       = 32,
   parameter int DATA_ADDRS_BITS = 10,
   parameter int DUMP_WORDS      = 1024
) (
   input logic                clk,
   input logic                rst,
   data_mem_dump_ctrl_if.master bus
);

   localparam logic [DATA_ADDRS_BITS-1:0] LAST_ADDR =
      DATA_ADDRS_BITS'(DUMP_WORDS - 1);

   state_e                     state_q, state_d;
   logic [DATA_ADDRS_BITS-1:0] addr_q, addr_d;
   logic [7:0]                 tx_data_q, tx_data_d;
   logic                       tx_start_q, tx_start_d;
   logic                       done_q, done_d;
   logic                       aborted_q, aborted_d;

   logic                       ser_load, ser_advance, ser_last;
   logic [7:0]                 ser_byte;
`ifdef DUMP_CHECKSUM_EN
   logic                       csum_clr, csum_acc;
   logic [7:0]                 csum;
`endif

   word_byte_serializer #(.PROC_BITS(PROC_BITS)) u_ser (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ser_load),
      .word_i     (bus.i_mem_data),
      .advance_i  (ser_advance),
`ifdef DUMP_CHECKSUM_EN
      .csum_clr_i (csum_clr),
      .csum_acc_i (csum_acc),
      .csum_o     (csum),
`endif
      .byte_o     (ser_byte),
      .last_o     (ser_last)
   );

   // Next-state and registered-output logic of the dump FSM.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      done_d      = 1'b0;
      aborted_d   = 1'b0;
      ser_load    = 1'b0;
      ser_advance = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_clr    = 1'b0;
      csum_acc    = 1'b0;
`endif
      if (state_q == ST_IDLE) begin
         if (bus.i_start) begin
            if (bus.i_halted) begin
               addr_d  = '0;
               state_d = ST_ADDR;
`ifdef DUMP_CHECKSUM_EN
               csum_clr = 1'b1;
`endif
            end else begin
               aborted_d = 1'b1;
            end
         end
      end else if (!bus.i_halted) begin
         // Pipeline resumed under us: drop the dump, a pending done loses.
         state_d   = ST_IDLE;
         addr_d    = '0;
         aborted_d = 1'b1;
      end else begin
         case (state_q)
            ST_ADDR:  state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_LATCH;
            ST_LATCH: begin
               ser_load = 1'b1;
               state_d  = ST_SEND;
            end
            ST_SEND: begin
               tx_data_d  = ser_byte;
               tx_start_d = 1'b1;
               state_d    = ST_WAIT_TX;
`ifdef DUMP_CHECKSUM_EN
               csum_acc   = 1'b1;
`endif
            end
            ST_WAIT_TX: begin
               if (bus.i_tx_done) begin
                  if (!ser_last) begin
                     ser_advance = 1'b1;
                     state_d     = ST_SEND;
                  end else if (addr_q != LAST_ADDR) begin
                     addr_d  = addr_q + DATA_ADDRS_BITS'(1);
                     state_d = ST_ADDR;
                  end else begin
`ifdef DUMP_CHECKSUM_EN
                     state_d = ST_SEND_CSUM;
`else
                     done_d  = 1'b1;
                     addr_d  = '0;
                     state_d = ST_IDLE;
`endif
                  end
               end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_SEND_CSUM: begin
               tx_data_d  = csum;
               tx_start_d = 1'b1;
               state_d    = ST_WAIT_CSUM;
            end
            ST_WAIT_CSUM: begin
               if (bus.i_tx_done) begin
                  done_d  = 1'b1;
                  addr_d  = '0;
                  state_d = ST_IDLE;
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, address and registered output pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
      end
   end

   assign bus.o_busy               = (state_q != ST_IDLE);
   assign bus.o_debug_read_data    = (state_q != ST_IDLE);
   assign bus.o_debug_read_address = addr_q;
   assign bus.o_tx_data            = tx_data_q;
   assign bus.o_tx_start           = tx_start_q;
   assign bus.o_done               = done_q;
   assign bus.o_aborted            = aborted_q;

endmodule

// File: tb/tb_data_mem_dump_ctrl.sv
// Directed, scoreboard-based bench for data_mem_dump_ctrl (4-word dump).
module tb_data_mem_dump_ctrl;

   localparam int PB  = 32;
   localparam int AB  = 10;
   localparam int DW  = 4;
`ifdef DUMP_CHECKSUM_EN
   localparam int NBYTES = DW * (PB / 8) + 1;
`else
   localparam int NBYTES = DW * (PB / 8);
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_mem_dump_ctrl_if #(.PROC_BITS(PB), .DATA_ADDRS_BITS(AB)) bus ();

   data_mem_dump_ctrl #(.PROC_BITS(PB), .DATA_ADDRS_BITS(AB), .DUMP_WORDS(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [PB-1:0] mem [DW];
   logic [7:0]    exp_q [$];
   logic [AB-1:0] trace [$];
   int            chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
   int            start_cnt = 0, done_cnt = 0, abort_cnt = 0;
   logic          model_done = 1'b0, spur_done = 1'b0;
   int            uart_cnt = 0;
   logic          prev_rd = 1'b0;
   logic [AB-1:0] prev_addr = '0;

   assign bus.i_tx_done = model_done | spur_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Synchronous BRAM read with combinational load filter (word mode).
   always @(posedge clk)
      bus.i_mem_data <= (bus.o_debug_read_address < AB'(DW)) ?
                        mem[bus.o_debug_read_address[1:0]] : '0;

   // UART model: done pulse 5 cycles after each start.
   always @(negedge clk) begin
      model_done = 1'b0;
      if (rst) uart_cnt = 0;
      else if (bus.o_tx_start) uart_cnt = 5;
      else if (uart_cnt != 0) begin
         uart_cnt--;
         if (uart_cnt == 0) model_done = 1'b1;
      end
   end

   // Output monitor: byte scoreboard, pulse counters, address trace.
   always @(negedge clk) begin
      if (bus.o_tx_start) begin
         start_cnt++;
         check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("tx_byte", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
      end
      if (bus.o_done)    done_cnt++;
      if (bus.o_aborted) abort_cnt++;
      if (bus.o_debug_read_data && (!prev_rd || bus.o_debug_read_address != prev_addr))
         trace.push_back(bus.o_debug_read_address);
      prev_rd   = bus.o_debug_read_data;
      prev_addr = bus.o_debug_read_address;
   end

   task automatic clear_counts();
      start_cnt = 0; done_cnt = 0; abort_cnt = 0;
      trace.delete();
   endtask

   task automatic push_expected();
      logic [7:0] csum = 8'h00;
      exp_q.delete();
      for (int w = 0; w < DW; w++)
         for (int b = 0; b < PB / 8; b++) begin
            exp_q.push_back(mem[w][8*b +: 8]);
            csum ^= mem[w][8*b +: 8];
         end
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(csum);
`endif
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 bus.i_start = 1'b1;
      @(posedge clk); #1 bus.i_start = 1'b0;
   endtask

   task automatic wait_not_busy(input string tag, input int budget);
      int n = 0;
      while (bus.o_busy && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(n < budget), 32'd1);
   endtask

   task automatic wait_starts(input string tag, input int cnt, input int budget);
      int n = 0;
      while (start_cnt < cnt && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(n < budget), 32'd1);
   endtask

   task automatic check_trace(input string tag);
      check({tag, "_len"}, 32'(trace.size()), 32'(DW));
      for (int i = 0; i < DW && i < trace.size(); i++)
         check({tag, "_addr"}, 32'(trace[i]), 32'(i));
   endtask

   // Complete dump; optionally injects a mid-dump start and a spurious done in SEND.
   task automatic run_dump(input string tag, input bit inject);
      push_expected();
      clear_counts();
      pulse_start();
      if (inject) begin
         int n = 0;
         while (bus.o_debug_read_address != AB'(1) && n < 500) begin
            @(posedge clk); #1;
            n++;
         end
         check({tag, "_reach_addr1"}, 32'(n < 500), 32'd1);
         repeat (3) begin @(posedge clk); #1; end   // ADDR -> WAIT -> LATCH -> SEND
         bus.i_start = 1'b1;
         spur_done   = 1'b1;
         @(posedge clk); #1;
         bus.i_start = 1'b0;
         spur_done   = 1'b0;
      end
      wait_not_busy({tag, "_finish"}, 2000);
      @(posedge clk); #1;
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_start_cnt"}, 32'(start_cnt), 32'(NBYTES));
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_busy_low"}, 32'(bus.o_busy), 32'd0);
      check({tag, "_rd_low"}, 32'(bus.o_debug_read_data), 32'd0);
      check({tag, "_addr_zero"}, 32'(bus.o_debug_read_address), 32'd0);
      check_trace(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mem[0] = 32'h1122_3344;
      mem[1] = 32'hAABB_CCDD;
      mem[2] = 32'h0000_0000;
      mem[3] = 32'hFFFF_FFFF;
      bus.i_start  = 1'b0;
      bus.i_halted = 1'b1;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("rst_busy", 32'(bus.o_busy), 32'd0);
      check("rst_rd", 32'(bus.o_debug_read_data), 32'd0);
      check("rst_addr", 32'(bus.o_debug_read_address), 32'd0);
      check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
      check("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
      check("rst_done", 32'(bus.o_done), 32'd0);
      check("rst_aborted", 32'(bus.o_aborted), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Full dump, byte order and address trace.
      run_dump("dump1", 1'b0);

      // Start while not halted: rejected with an abort pulse.
      clear_counts();
      bus.i_halted = 1'b0;
      pulse_start();
      check("nohalt_aborted", 32'(bus.o_aborted), 32'd1);
      check("nohalt_busy", 32'(bus.o_busy), 32'd0);
      @(posedge clk); #1;
      check("nohalt_pulse_once", 32'(abort_cnt), 32'd1);
      bus.i_halted = 1'b1;

      // Halt drop in WAIT_TX of word 2 (after its first byte).
      push_expected();
      for (int i = 0; i < NBYTES - 2 * (PB / 8) - 1; i++) void'(exp_q.pop_back());
      clear_counts();
      pulse_start();
      wait_starts("abort_reach", 2 * (PB / 8) + 1, 1000);
      bus.i_halted = 1'b0;
      @(posedge clk); #1;
      check("abort_pulse", 32'(bus.o_aborted), 32'd1);
      check("abort_busy", 32'(bus.o_busy), 32'd0);
      check("abort_rd", 32'(bus.o_debug_read_data), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      check("abort_cnt", 32'(abort_cnt), 32'd1);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_starts", 32'(start_cnt), 32'(2 * (PB / 8) + 1));
      check("abort_queue", 32'(exp_q.size()), 32'd0);
      bus.i_halted = 1'b1;

      // Mid-dump start and spurious done must be ignored.
      run_dump("ignore", 1'b1);

      // Async reset in WAIT_TX of word 1, then a clean full dump.
      push_expected();
      clear_counts();
      pulse_start();
      wait_starts("rst_reach", PB / 8 + 1, 1000);
      #2 rst = 1'b1;
      #1;
      check("mrst_busy", 32'(bus.o_busy), 32'd0);
      check("mrst_rd", 32'(bus.o_debug_read_data), 32'd0);
      check("mrst_addr", 32'(bus.o_debug_read_address), 32'd0);
      check("mrst_tx_data", 32'(bus.o_tx_data), 32'd0);
      check("mrst_tx_start", 32'(bus.o_tx_start), 32'd0);
      check("mrst_done_aborted", 32'({bus.o_done, bus.o_aborted}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("mrst_no_pulses", 32'(done_cnt + abort_cnt), 32'd0);
      exp_q.delete();
      run_dump("after_rst", 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
